// File: rtl/seq_det_pkg.sv
// Shared types and next-state function for the "010" Moore sequence detector.
package seq_det_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam state_t MATCH_STATE = S3;

  // Overlapping "010" detector; S3 behaves like S1 for the following bit.
  function automatic state_t next_state(input state_t s, input logic b);
    state_t n;
    case (s)
      S0:      n = b ? S0 : S1;
      S1:      n = b ? S2 : S1;
      S2:      n = b ? S0 : S3;
      default: n = b ? S2 : S1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_detect_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx;
  logic          found;
  int unsigned   idx;

  // Grant is forced low while reset is asserted.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr_q) + off) % N;
      if (!found && reset && req[IW'(idx)]) begin
        grant[IW'(idx)] = 1'b1;
        gidx            = IW'(idx);
        found           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
    end
  end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Time-shared "010" detector over NUM_CH serial channels with round-robin service.
// Optional per-channel match counters: define SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_arbiter
  import seq_det_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_valid,
  input  logic [NUM_CH-1:0] req_bit,
  output logic [NUM_CH-1:0] req_ready,
  input  logic [NUM_CH-1:0] chan_clr,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch,
  output logic              busy
`ifdef SEQ_DETECT_MATCH_CNT_EN
  ,
  input  logic [CH_W-1:0]   cnt_sel,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_out
`endif
);

  state_t [NUM_CH-1:0] state_q;
  state_t [NUM_CH-1:0] state_d;
  logic   [NUM_CH-1:0] elig;
  logic   [NUM_CH-1:0] grant;
  logic   [NUM_CH-1:0] hit;
  logic   [NUM_CH-1:0] active;
  logic   [CH_W-1:0]   hit_ch;
  logic                adv;

  // A clear in the same cycle blocks the grant so the bit is retried.
  assign elig      = req_valid & ~chan_clr;
  assign adv       = |grant;
  assign req_ready = grant;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (elig),
    .advance (adv),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    hit     = '0;
    active  = '0;
    hit_ch  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (chan_clr[i]) begin
        state_d[i] = S0;
      end else if (grant[i]) begin
        state_d[i] = next_state(state_q[i], req_bit[i]);
        hit[i]     = (state_d[i] == MATCH_STATE);
      end
      active[i] = (state_d[i] != S0);
      if (hit[i]) hit_ch = CH_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= S0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_valid <= |hit;
      if (|hit) match_ch <= hit_ch;
      busy        <= |active;
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  // Clears win over a simultaneous increment; counts saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cnt_clr || chan_clr[i]) begin
          cnt_q[i] <= '0;
        end else if (hit[i] && (cnt_q[i] != CNT_W'(CNT_MAX))) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_out = (32'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed self-checking bench for seq_detect_arbiter (NUM_CH = 4).
module tb_seq_detect_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_bit;
  logic [3:0] req_ready;
  logic [3:0] chan_clr;
  logic       match_valid;
  logic [1:0] match_ch;
  logic       busy;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [1:0] cnt_sel;
  logic       cnt_clr;
  logic [7:0] cnt_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_arbiter #(.NUM_CH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_bit     (req_bit),
    .req_ready   (req_ready),
    .chan_clr    (chan_clr),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .busy        (busy)
`ifdef SEQ_DETECT_MATCH_CNT_EN
    ,
    .cnt_sel     (cnt_sel),
    .cnt_clr     (cnt_clr),
    .cnt_out     (cnt_out)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
    req_valid = v;
    req_bit   = b;
    chan_clr  = c;
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    req_valid = 4'($urandom);
    req_bit   = 4'($urandom);
    chan_clr  = 4'b0000;
    tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    n_cmp++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL reset_mv: got %b exp 0", match_valid); end
    n_cmp++; if (match_ch !== 2'd0) begin n_err++; $display("FAIL reset_mch: got %0d exp 0", match_ch); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
`ifdef SEQ_DETECT_MATCH_CNT_EN
    n_cmp++; if (cnt_out !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", cnt_out); end
`endif
    tick();
    reset = 1'b1;
    drive(4'b1111, 4'b0000, 4'b0000);
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b exp 0001", req_ready); end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_single;
    logic [3:0] bits [5] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic       expm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, bits[k], 4'b0000);
      n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready[%0d]: got %b exp 0001", k, req_ready); end
      tick();
      n_cmp++; if (match_valid !== expm[k]) begin n_err++; $display("FAIL single_mv[%0d]: got %b exp %b", k, match_valid, expm[k]); end
      if (expm[k]) begin
        n_cmp++; if (match_ch !== 2'd0) begin n_err++; $display("FAIL single_mch[%0d]: got %0d exp 0", k, match_ch); end
      end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy[%0d]: got %b exp 1", k, busy); end
    end
    drive(4'b0000, 4'b1111, 4'b0001);
    tick();
    n_cmp++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_mv: got %b exp 0", match_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_clr_busy: got %b exp 0", busy); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_rdy;
    // Move the pointer back to 0 with a harmless bit on ch3 (S0 stays S0).
    drive(4'b1000, 4'b1000, 4'b0000);
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL fair_pre_ready: got %b exp 1000", req_ready); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_pre_busy: got %b exp 0", busy); end
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, (k / 4 == 1) ? 4'b1111 : 4'b0000, 4'b0000);
      exp_rdy = 4'(1 << (k % 4));
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_ready[%0d]: got %b exp %b", k, req_ready, exp_rdy); end
      tick();
      n_cmp++; if (match_valid !== (k >= 8)) begin n_err++; $display("FAIL fair_mv[%0d]: got %b exp %b", k, match_valid, (k >= 8)); end
      if (k >= 8) begin
        n_cmp++; if (match_ch !== 2'(k - 8)) begin n_err++; $display("FAIL fair_mch[%0d]: got %0d exp %0d", k, match_ch, k - 8); end
      end
    end
    drive(4'b0000, 4'b0000, 4'b1111);
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_clr_busy: got %b exp 0", busy); end
  endtask

  task automatic test_interleave;
    // Pointer starts at 0; ungranted channels see bits that would corrupt them.
    logic [3:0] v    [8] = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0010, 4'b0100, 4'b0100};
    logic [3:0] b    [8] = '{4'b0100, 4'b0110, 4'b0110, 4'b0100, 4'b0010, 4'b0000, 4'b0100, 4'b0000};
    logic [3:0] rdy  [8] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b0100, 4'b0100};
    logic       mv   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] mch  [8] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    for (int k = 0; k < 8; k++) begin
      drive(v[k], b[k], 4'b0000);
      n_cmp++; if (req_ready !== rdy[k]) begin n_err++; $display("FAIL inter_ready[%0d]: got %b exp %b", k, req_ready, rdy[k]); end
      tick();
      n_cmp++; if (match_valid !== mv[k]) begin n_err++; $display("FAIL inter_mv[%0d]: got %b exp %b", k, match_valid, mv[k]); end
      if (mv[k]) begin
        n_cmp++; if (match_ch !== mch[k]) begin n_err++; $display("FAIL inter_mch[%0d]: got %0d exp %0d", k, match_ch, mch[k]); end
      end
    end
    drive(4'b0000, 4'b0000, 4'b1111);
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL inter_clr_busy: got %b exp 0", busy); end
  endtask

  task automatic test_clear_collision;
    logic [3:0] b  [4] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000};
    logic       mv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SEQ_DETECT_MATCH_CNT_EN
    cnt_sel = 2'd3;
`endif
    for (int k = 0; k < 4; k++) begin
      drive(4'b1000, b[k], 4'b0000);
      tick();
      n_cmp++; if (match_valid !== mv[k]) begin n_err++; $display("FAIL coll_prep_mv[%0d]: got %b exp %b", k, match_valid, mv[k]); end
    end
    n_cmp++; if (match_ch !== 2'd3) begin n_err++; $display("FAIL coll_prep_mch: got %0d exp 3", match_ch); end
`ifdef SEQ_DETECT_MATCH_CNT_EN
    n_cmp++; if (cnt_out !== 8'd1) begin n_err++; $display("FAIL coll_cnt_before: got %0d exp 1", cnt_out); end
`endif
    // ch3 is in S2; bit 0 would match, but the clear blocks the grant.
    drive(4'b1000, 4'b0000, 4'b1000);
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL coll_ready: got %b exp 0000", req_ready); end
    tick();
    n_cmp++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL coll_mv: got %b exp 0", match_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL coll_busy: got %b exp 0", busy); end
`ifdef SEQ_DETECT_MATCH_CNT_EN
    n_cmp++; if (cnt_out !== 8'd0) begin n_err++; $display("FAIL coll_cnt_after: got %0d exp 0", cnt_out); end
`endif
    drive(4'b1000, 4'b0000, 4'b0000);
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL coll_retry_ready: got %b exp 1000", req_ready); end
    tick();
    n_cmp++; if (match_valid !== 1'b0) begin n_err++; $display("FAIL coll_retry_mv: got %b exp 0", match_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL coll_retry_busy: got %b exp 1", busy); end
    drive(4'b0000, 4'b0000, 4'b1111);
    tick();
  endtask

`ifdef SEQ_DETECT_MATCH_CNT_EN
  task automatic test_counter;
    cnt_sel = 2'd2;
    drive(4'b0100, 4'b0000, 4'b0000); tick();
    drive(4'b0100, 4'b0100, 4'b0000); tick();
    drive(4'b0100, 4'b0000, 4'b0000); tick();
    n_cmp++; if (cnt_out !== 8'd1) begin n_err++; $display("FAIL cnt_first: got %0d exp 1", cnt_out); end
    for (int m = 2; m <= 300; m++) begin
      drive(4'b0100, 4'b0100, 4'b0000); tick();
      drive(4'b0100, 4'b0000, 4'b0000); tick();
      if (m == 254) begin
        n_cmp++; if (cnt_out !== 8'd254) begin n_err++; $display("FAIL cnt_254: got %0d exp 254", cnt_out); end
      end
    end
    n_cmp++; if (cnt_out !== 8'd255) begin n_err++; $display("FAIL cnt_sat: got %0d exp 255", cnt_out); end
    n_cmp++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL cnt_sat_mv: got %b exp 1", match_valid); end
    // Clear lands on the same edge as a match: clear wins.
    drive(4'b0100, 4'b0100, 4'b0000); tick();
    cnt_clr = 1'b1;
    drive(4'b0100, 4'b0000, 4'b0000); tick();
    cnt_clr = 1'b0;
    n_cmp++; if (match_valid !== 1'b1) begin n_err++; $display("FAIL cnt_clr_mv: got %b exp 1", match_valid); end
    n_cmp++; if (cnt_out !== 8'd0) begin n_err++; $display("FAIL cnt_clr: got %0d exp 0", cnt_out); end
    drive(4'b0100, 4'b0100, 4'b0000); tick();
    drive(4'b0100, 4'b0000, 4'b0000); tick();
    n_cmp++; if (cnt_out !== 8'd1) begin n_err++; $display("FAIL cnt_after_clr: got %0d exp 1", cnt_out); end
    drive(4'b0000, 4'b0000, 4'b0000);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef SEQ_DETECT_MATCH_CNT_EN
    cnt_sel = 2'd0;
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_fairness();
    test_interleave();
    test_clear_collision();
`ifdef SEQ_DETECT_MATCH_CNT_EN
    test_counter();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
